// File: rtl/dm_ctrl.sv
// dm_ctrl: byte-addressed little-endian data memory with configurable wait states and a
// single-cycle response pulse. Define DM_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module dm_ctrl #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam logic [2:0] DmWord          = 3'd0;
    localparam logic [2:0] DmHalfword      = 3'd1;
    localparam logic [2:0] DmHalfwordUnsig = 3'd2;
    localparam logic [2:0] DmByte          = 3'd3;
    localparam logic [2:0] DmByteUnsig     = 3'd4;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] byte_addr [4];
    logic [31:0]       raw;
    logic [31:0]       load_data;
    logic [3:0]        byte_en;
    logic              type_ok;
    logic              fault;
    logic              accept;
    logic              do_write;

    assign accept = req_valid && (state_q == StIdle);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                type_q  <= req_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = StBusy;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) state_d = StResp;
                else             cnt_d   = cnt_q - 4'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Decode of the latched access width
    always_comb begin
        byte_en = 4'b0000;
        type_ok = 1'b1;
        case (type_q)
            DmByte, DmByteUnsig:         byte_en = 4'b0001;
            DmHalfword, DmHalfwordUnsig: byte_en = 4'b0011;
            DmWord:                      byte_en = 4'b1111;
            default:                     type_ok = 1'b0;
        endcase
    end

`ifdef DM_ALIGN_CHECK_EN
    logic misalign;
    always_comb begin
        misalign = 1'b0;
        if (byte_en == 4'b0011) misalign = addr_q[0];
        if (byte_en == 4'b1111) misalign = |addr_q[1:0];
    end
    assign fault = !type_ok || misalign;
`else
    assign fault = !type_ok;
`endif

    // Byte lanes wrap modulo the memory size
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = addr_q + ADDR_W'(k);
        end
    end

    assign raw = {mem[byte_addr[3]], mem[byte_addr[2]], mem[byte_addr[1]], mem[byte_addr[0]]};

    always_comb begin
        load_data = '0;
        case (type_q)
            DmByte:          load_data = {{24{raw[7]}}, raw[7:0]};
            DmByteUnsig:     load_data = {24'd0, raw[7:0]};
            DmHalfword:      load_data = {{16{raw[15]}}, raw[15:0]};
            DmHalfwordUnsig: load_data = {16'd0, raw[15:0]};
            DmWord:          load_data = raw;
            default:         load_data = '0;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid && fault;
        resp_rdata = (resp_valid && !we_q && !fault) ? load_data : 32'd0;
    end

    // Store commits on the edge leaving RESP unless a reset aborts it
    assign do_write = (state_q == StResp) && we_q && !fault && !rst;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (do_write && byte_en[k]) begin
                mem[byte_addr[k]] <= wdata_q[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: three instances (0, 3 and 2 wait states) against a
// transaction-level memory model, plus directed literal checks.
module tb_dm_ctrl;
    localparam int AW  = 9;
    localparam int NI  = 3;
    localparam int MSZ = 512;

    localparam logic [2:0] TWord  = 3'd0;
    localparam logic [2:0] THalf  = 3'd1;
    localparam logic [2:0] THalfU = 3'd2;
    localparam logic [2:0] TByte  = 3'd3;
    localparam logic [2:0] TByteU = 3'd4;

    logic          clk;
    logic          rst;
    logic          req_valid  [NI];
    logic          req_ready  [NI];
    logic          req_we     [NI];
    logic [2:0]    req_type   [NI];
    logic [AW-1:0] req_addr   [NI];
    logic [31:0]   req_wdata  [NI];
    logic          resp_valid [NI];
    logic [31:0]   resp_rdata [NI];
    logic          resp_err   [NI];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 3 : 2;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dm_ctrl #(
            .ADDR_W     (AW),
            .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 3 : 2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_type  (req_type[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0]  mmem    [NI][MSZ];
    bit          m_idle  [NI];
    int          m_resp  [NI];
    logic        m_we    [NI];
    logic [8:0]  m_addr  [NI];
    logic [31:0] m_wdata [NI];
    int          m_n     [NI];
    logic [31:0] m_rdata [NI];
    logic        m_err   [NI];
    int          ec = 0;

    function automatic int size_of(input logic [2:0] typ);
        case (typ)
            TByte, TByteU: return 1;
            THalf, THalfU: return 2;
            TWord:         return 4;
            default:       return 0;
        endcase
    endfunction

    task automatic model_accept(input int i);
        int          n;
        logic [31:0] v;
        logic        err;
        n   = size_of(req_type[i]);
        err = (n == 0);
`ifdef DM_ALIGN_CHECK_EN
        if (n > 1 && (int'(req_addr[i]) % n) != 0) err = 1'b1;
`endif
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mmem[i][(int'(req_addr[i]) + k) % MSZ];
        if (req_type[i] == TByte) v = {{24{v[7]}}, v[7:0]};
        if (req_type[i] == THalf) v = {{16{v[15]}}, v[15:0]};
        m_idle[i]  = 0;
        m_resp[i]  = ec + 1 + wait_of(i);
        m_we[i]    = req_we[i];
        m_addr[i]  = req_addr[i];
        m_wdata[i] = req_wdata[i];
        m_n[i]     = err ? 0 : n;
        m_err[i]   = err;
        m_rdata[i] = (req_we[i] || err) ? 32'd0 : v;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_idle[i] = 1;
            m_resp[i] = 0;
            for (int a = 0; a < MSZ; a++) mmem[i][a] = 8'hxx;
        end
        forever begin
            @(posedge clk);
            ec++;
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    m_idle[i] = 1;
                end else if (m_idle[i]) begin
                    if (req_valid[i]) model_accept(i);
                end else if (ec == m_resp[i]) begin
                    if (m_we[i]) begin
                        for (int k = 0; k < m_n[i]; k++)
                            mmem[i][(int'(m_addr[i]) + k) % MSZ] = m_wdata[i][8*k +: 8];
                    end
                    m_idle[i] = 1;
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model
    always @(negedge clk) begin
        logic ev;
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                ev = !m_idle[i] && ((ec + 1) == m_resp[i]);
                check($sformatf("ready[%0d]", i), {31'd0, req_ready[i]}, {31'd0, m_idle[i]});
                check($sformatf("resp_valid[%0d]", i), {31'd0, resp_valid[i]}, {31'd0, ev});
                if (ev) begin
                    check($sformatf("resp_err[%0d]", i), {31'd0, resp_err[i]}, {31'd0, m_err[i]});
                    if (!$isunknown(m_rdata[i]))
                        check($sformatf("resp_rdata[%0d]", i), resp_rdata[i], m_rdata[i]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int i, input logic we, input logic [2:0] typ,
                         input logic [8:0] addr, input logic [31:0] wd);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_type[i]  = typ;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
    endtask

    // Returns at posedge+1 of the accepting edge
    task automatic wait_accept(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 40);
        check($sformatf("accept_seen[%0d]", i), {31'd0, req_ready[i]}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int i, output logic [31:0] rd, output logic err,
                             output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid[i] && lat < 40);
        check($sformatf("resp_seen[%0d]", i), {31'd0, resp_valid[i]}, 32'd1);
        rd  = resp_rdata[i];
        err = resp_err[i];
    endtask

    task automatic scramble(input int i);
        req_valid[i] = 1'b0;
        req_we[i]    = 1'($urandom);
        req_type[i]  = 3'($urandom);
        req_addr[i]  = 9'($urandom);
        req_wdata[i] = $urandom;
    endtask

    task automatic do_req(input int i, input logic we, input logic [2:0] typ,
                          input logic [8:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int n;
        drive(i, we, typ, addr, wd);
        wait_accept(i, n);
        scramble(i);
        wait_resp(i, rd, err, lat);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_type[i]  = TWord;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_ready[%0d]", i), {31'd0, req_ready[i]}, 32'd1);
            check($sformatf("rst_valid[%0d]", i), {31'd0, resp_valid[i]}, 32'd0);
            check($sformatf("rst_rdata[%0d]", i), resp_rdata[i], 32'd0);
            check($sformatf("rst_err[%0d]", i), {31'd0, resp_err[i]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1;

        // Word store/load, zero wait states
        do_req(0, 1'b1, TWord, 9'h010, 32'h8765_4321, rd, er, lat);
        check("t1_st_lat", lat, 1);
        check("t1_st_err", {31'd0, er}, 0);
        check("t1_st_rdata", rd, 0);
        do_req(0, 1'b0, TWord, 9'h010, 32'h0, rd, er, lat);
        check("t1_ld_lat", lat, 1);
        check("t1_ld_rdata", rd, 32'h8765_4321);
        check("t1_ld_err", {31'd0, er}, 0);

        // Sub-word loads
        do_req(0, 1'b0, TByte, 9'h013, 32'h0, rd, er, lat);
        check("t2_lb", rd, 32'hFFFF_FF87);
        do_req(0, 1'b0, TByteU, 9'h013, 32'h0, rd, er, lat);
        check("t2_lbu", rd, 32'h0000_0087);
        do_req(0, 1'b0, THalf, 9'h012, 32'h0, rd, er, lat);
        check("t2_lh", rd, 32'hFFFF_8765);
        do_req(0, 1'b0, THalfU, 9'h010, 32'h0, rd, er, lat);
        check("t2_lhu", rd, 32'h0000_4321);

        // Unknown types: error, no write
        do_req(0, 1'b1, 3'd6, 9'h010, 32'hDEAD_BEEF, rd, er, lat);
        check("bad_st_err", {31'd0, er}, 1);
        do_req(0, 1'b0, 3'd7, 9'h010, 32'h0, rd, er, lat);
        check("bad_ld_err", {31'd0, er}, 1);
        check("bad_ld_rdata", rd, 0);
        do_req(0, 1'b0, TWord, 9'h010, 32'h0, rd, er, lat);
        check("bad_no_write", rd, 32'h8765_4321);

`ifndef DM_ALIGN_CHECK_EN
        // Word wraps from the top address to byte 0
        do_req(0, 1'b1, TWord, 9'h1FE, 32'hAABB_CCDD, rd, er, lat);
        check("t4_st_err", {31'd0, er}, 0);
        do_req(0, 1'b0, TByteU, 9'h1FE, 32'h0, rd, er, lat);
        check("t4_b1fe", rd, 32'hDD);
        do_req(0, 1'b0, TByteU, 9'h1FF, 32'h0, rd, er, lat);
        check("t4_b1ff", rd, 32'hCC);
        do_req(0, 1'b0, TByteU, 9'h000, 32'h0, rd, er, lat);
        check("t4_b000", rd, 32'hBB);
        do_req(0, 1'b0, TByteU, 9'h001, 32'h0, rd, er, lat);
        check("t4_b001", rd, 32'hAA);
        do_req(0, 1'b0, TWord, 9'h1FE, 32'h0, rd, er, lat);
        check("t4_word", rd, 32'hAABB_CCDD);
`endif

        // Misaligned word store
        do_req(0, 1'b1, TByte, 9'h021, 32'h0000_0033, rd, er, lat);
        do_req(0, 1'b1, TWord, 9'h021, 32'h1111_1111, rd, er, lat);
`ifdef DM_ALIGN_CHECK_EN
        check("t5_err", {31'd0, er}, 1);
        check("t5_lat", lat, 1);
        do_req(0, 1'b0, TByteU, 9'h021, 32'h0, rd, er, lat);
        check("t5_nowrite", rd, 32'h33);
`else
        check("t5_err", {31'd0, er}, 0);
        do_req(0, 1'b0, TByteU, 9'h021, 32'h0, rd, er, lat);
        check("t5_written", rd, 32'h11);
`endif

        // Three wait states, second request held while busy
        do_req(1, 1'b1, TWord, 9'h050, 32'hCAFE_F00D, rd, er, lat);
        check("t3_st_lat", lat, 4);
        drive(1, 1'b0, TWord, 9'h050, 32'h0);
        wait_accept(1, n);
        drive(1, 1'b0, TByteU, 9'h050, 32'h0);
        wait_resp(1, rd, er, lat);
        check("t3_ld_lat", lat, 4);
        check("t3_ld_rdata", rd, 32'hCAFE_F00D);
        wait_accept(1, n);
        check("t3_second_accept_gap", n, 1);
        scramble(1);
        wait_resp(1, rd, er, lat);
        check("t3_second_lat", lat, 4);
        check("t3_second_rdata", rd, 32'h0D);
        @(posedge clk);
        #1;

        // Reset during BUSY aborts the store
        do_req(2, 1'b1, TByte, 9'h040, 32'h0, rd, er, lat);
        check("t6_init_lat", lat, 3);
        drive(2, 1'b1, TByte, 9'h040, 32'h0000_005A);
        wait_accept(2, n);
        scramble(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t6_no_resp", {31'd0, resp_valid[2]}, 0);
            check("t6_ready", {31'd0, req_ready[2]}, 1);
        end
        @(posedge clk);
        #1;
        do_req(2, 1'b0, TByteU, 9'h040, 32'h0, rd, er, lat);
        check("t6_nowrite", rd, 32'h0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
